// File: rtl/axi_stream_mm_writer.sv
// Streams 64-bit beats into memory as AXI4 INCR write bursts, one burst in flight, never crossing 4 KB.
// W data is a combinational pass-through of the stream; done pulses one cycle after the final B response.
module axi_stream_mm_writer #(
    parameter int AXI_IDWIDTH = 4,
    parameter int MAX_BURST   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [63:0]            cmd_addr,
    input  logic [31:0]            cmd_len,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [63:0]            s_data,
    output logic                   done,
    output logic                   err,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [63:0]            m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [AXI_IDWIDTH-1:0] m_axi_awid,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    output logic                   m_axi_wlast,
    output logic [63:0]            m_axi_wdata,
    output logic [7:0]             m_axi_wstrb,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    input  logic [1:0]             m_axi_bresp,
    input  logic [AXI_IDWIDTH-1:0] m_axi_bid
);

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic [7:0]  awlen_q, awlen_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic [8:0]  beats;
    logic [63:0] cmd_addr_al;
    logic        unused_bits;

    // Beats for the next burst: bounded by what is left, MAX_BURST and the room to the 4 KB line.
    function automatic logic [8:0] burst_beats(input logic [31:0] rem, input logic [8:0] slot);
        logic [31:0] lim;
        logic [31:0] room;
        lim  = (rem < 32'(MAX_BURST)) ? rem : 32'(MAX_BURST);
        room = 32'd512 - {23'd0, slot};
        if (room < lim) lim = room;
        return lim[8:0];
    endfunction

    assign cmd_addr_al = {cmd_addr[63:3], 3'b000};
    assign beats       = {1'b0, awlen_q} + 9'd1;
    assign unused_bits = ^{m_axi_bid, cmd_addr[2:0]};

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        awlen_d       = awlen_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        done_d        = 1'b0;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        s_ready       = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d = cmd_addr_al;
                    rem_d  = cmd_len;
                    err_d  = 1'b0;
                    cnt_d  = 8'd0;
                    if (cmd_len == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = AW;
                        awlen_d = 8'(burst_beats(cmd_len, cmd_addr_al[11:3]) - 9'd1);
                    end
                end
            end
            AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = W;
                    cnt_d   = 8'd0;
                end
            end
            W: begin
                m_axi_wvalid = s_valid;
                s_ready      = m_axi_wready;
                m_axi_wlast  = (cnt_q == awlen_q);
                if (s_valid && m_axi_wready) begin
                    cnt_d = 8'(cnt_q + 8'd1);
                    if (cnt_q == awlen_q) state_d = B;
                end
            end
            B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    err_d  = err_q | (m_axi_bresp != 2'b00);
                    rem_d  = rem_q - {23'd0, beats};
                    addr_d = addr_q + {52'd0, beats, 3'b000};
                    if (rem_d == 32'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = AW;
                        awlen_d = 8'(burst_beats(rem_d, addr_d[11:3]) - 9'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            awlen_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            awlen_q <= awlen_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_awlen  = awlen_q;
    assign m_axi_awid   = '0;
    assign m_axi_wdata  = s_data;
    assign m_axi_wstrb  = 8'hFF;
    assign done         = done_q;
    assign err          = err_q;

endmodule
